// File: rtl/db_pair_fsm_pkg.sv
// db_pair_fsm_pkg: shared types and defaults for the two-channel debouncer.
//   N_DEF      default tick counter width (sample period 2^N_DEF clk cycles)
//   db_state_e 3-bit per-channel filter state encoding
//   db_level   Moore level decode of a filter state
package db_pair_fsm_pkg;

  localparam int N_DEF = 19;

  typedef enum logic [2:0] {
    ZERO    = 3'd0,
    WAIT1_1 = 3'd1,
    WAIT1_2 = 3'd2,
    WAIT1_3 = 3'd3,
    ONE     = 3'd4,
    WAIT0_1 = 3'd5,
    WAIT0_2 = 3'd6,
    WAIT0_3 = 3'd7
  } db_state_e;

  // Output is high once the input has been accepted as 1, and stays high
  // while a falling edge is still being qualified.
  function automatic logic db_level(db_state_e st);
    return (st == ONE) || (st == WAIT0_1) || (st == WAIT0_2) || (st == WAIT0_3);
  endfunction

endpackage

// File: rtl/db_pair_fsm_if.sv
// db_pair_fsm_if: switch-side bundle of the debouncer.
//   sw_a, sw_b     raw switch inputs (driven by master)
//   a, b           debounced levels (driven by slave)
//   a_tick, b_tick one-cycle rising-edge pulses (driven by slave)
interface db_pair_fsm_if;
  logic sw_a;
  logic sw_b;
  logic a;
  logic b;
  logic a_tick;
  logic b_tick;

  modport master (output sw_a, sw_b, input a, b, a_tick, b_tick);
  modport slave  (input sw_a, sw_b, output a, b, a_tick, b_tick);
endinterface

// File: rtl/db_pair_fsm_channel.sv
// db_channel: one debounce channel.
//   clk, reset  clock, async active-high reset
//   sw          raw switch input (asynchronous)
//   m_tick      shared sample strobe, one cycle every 2^N clocks
//   lvl         debounced level
//   tick        one-cycle pulse aligned with the first cycle of lvl=1 after
//               a full 0->1 acceptance (only when DB_EDGE_TICK_EN is defined,
//               otherwise constant 0)
module db_channel
  import db_pair_fsm_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic sw,
  input  logic m_tick,
  output logic lvl,
  output logic tick
);

  logic [1:0] sync;
  logic       s;
  db_state_e  state;

  assign s = sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= '0;
      state <= ZERO;
    end else begin
      sync <= {sync[0], sw};
      case (state)
        ZERO:    if (s) state <= WAIT1_1;
        // opposite level beats the sample strobe and restarts the filter
        WAIT1_1: if (!s) state <= ZERO; else if (m_tick) state <= WAIT1_2;
        WAIT1_2: if (!s) state <= ZERO; else if (m_tick) state <= WAIT1_3;
        WAIT1_3: if (!s) state <= ZERO; else if (m_tick) state <= ONE;
        ONE:     if (!s) state <= WAIT0_1;
        WAIT0_1: if (s) state <= ONE; else if (m_tick) state <= WAIT0_2;
        WAIT0_2: if (s) state <= ONE; else if (m_tick) state <= WAIT0_3;
        WAIT0_3: if (s) state <= ONE; else if (m_tick) state <= ZERO;
        default: state <= ZERO;
      endcase
    end
  end

  assign lvl = db_level(state);

`ifdef DB_EDGE_TICK_EN
  // Registered copy of the WAIT1_3 -> ONE condition, so it lands in the
  // same cycle lvl first reads 1. WAIT0_k -> ONE recovery does not count.
  logic tick_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_q <= 1'b0;
    else       tick_q <= (state == WAIT1_3) && s && m_tick;
  end

  assign tick = tick_q;
`else
  assign tick = 1'b0;
`endif

endmodule

// File: rtl/db_pair_fsm.sv
// db_pair_fsm: two-channel switch debouncer feeding a downstream a/b FSM.
//   Parameter N  tick counter width; sample period 2^N clk cycles.
//   clk, reset   clock, async active-high reset (clears every register)
//   bus          db_pair_fsm_if.slave: sw_a/sw_b in, a/b and a_tick/b_tick out
// Optional feature macro: DB_EDGE_TICK_EN enables the rising-edge ticks;
// without it a_tick/b_tick are tied low and the port list is unchanged.
module db_pair_fsm
  import db_pair_fsm_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic          clk,
  input  logic          reset,
  db_pair_fsm_if.slave  bus
);

  localparam int NUM_CH = 2;

  logic [N-1:0]        cnt;
  logic                m_tick;
  logic [NUM_CH-1:0]   sw;
  logic [NUM_CH-1:0]   lvl;
  logic [NUM_CH-1:0]   tck;

  // Free-running, shared by both channels; strobe on the all-ones count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt + 1'b1;
  end

  assign m_tick = &cnt;

  assign sw = {bus.sw_b, bus.sw_a};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    db_channel u_ch (
      .clk    (clk),
      .reset  (reset),
      .sw     (sw[g]),
      .m_tick (m_tick),
      .lvl    (lvl[g]),
      .tick   (tck[g])
    );
  end

  assign bus.a      = lvl[0];
  assign bus.b      = lvl[1];
  assign bus.a_tick = tck[0];
  assign bus.b_tick = tck[1];

endmodule
